dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the MIPS core's load/store path. It answers the core's data-memory requests (Address, Write_data, MemRead, MemWrite) from an internal word array after a programmable latency. It signals completion with a one-cycle Mem_ready pulse, so the core can stall on it. It replaces the zero-latency combinational data memory when the core is built with a stall-capable memory stage.

## Interface
Parameters:
- DEPTH_LOG2, default 8: number of words in the array = 2^DEPTH_LOG2 (32-bit words).
- LATENCY, default 3: cycles from request sampled to Mem_ready. Legal range 1..15.

Ports:
- CLK  in  1  the single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MemRead  in  1  read request level, held by the core until Mem_ready.
- MemWrite  in  1  write request level, held by the core until Mem_ready.
- Address  in  32  byte address; word index = Address[DEPTH_LOG2+1:2].
- Write_data  in  32  store data.
- Read_data  out  32  load data; valid while Mem_ready=1, held afterwards.
- Mem_ready  out  1  one-cycle completion pulse.
- Mem_error  out  1  pulses with Mem_ready when the completed access was faulted.
- Busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - MemRead|MemWrite sampled at the clock edge: capture Address, Write_data and type into internal registers.
  - Load cnt = LATENCY-1.
  - Go to DONE if LATENCY=1, else go to WAIT.
- WAIT:
  - Inputs are ignored; captured values are used.
  - If cnt==1, go to DONE; else cnt decrements.
- Transition into DONE, on that edge:
  - Write: array[index] <= captured Write_data, unless faulted.
  - Read: Read_data <= array[index], or 32'd0 if faulted.
- DONE: Mem_ready=1 for exactly this cycle; next state is always IDLE.
- Fault conditions:
  - Captured Address[1:0] != 2'b00: no array write; Read_data=0.
  - Both MemRead and MemWrite high at capture: treated as write and Mem_error=1. The write is still performed if aligned.
- Address bits above DEPTH_LOG2+1 are ignored (wrap, no error).
- Array contents are not affected by reset and are undefined at power-up.
- All outputs are registered.

## Timing
- Reset values: state=IDLE, cnt=0, Read_data=0, Mem_ready=0, Mem_error=0, Busy=0.
- Request high in cycle 0 (sampled at the end-of-cycle-0 edge) gives Mem_ready high in cycle LATENCY.
- Busy is high in cycles 1..LATENCY.
- Read-after-write: a read issued after a write's Mem_ready returns the new data.
- Throughput: at most one access per LATENCY+1 cycles. The mandatory IDLE cycle after DONE means a request still held during DONE is not served twice. The core drops or changes it on the Mem_ready edge.
- Request deasserted during WAIT: the access still completes and Mem_ready still pulses.
- RESET low mid-operation, at any time:
  - Immediately returns to IDLE and clears outputs.
  - A write not yet at its DONE edge is discarded.
  - A write already committed remains.
- No request in IDLE: outputs stay 0; Read_data holds its last value.

## Test plan
- Reset then single write, LATENCY=3: MemWrite=1, Address=0x10, Write_data=0xDEADBEEF in cycle 0.
  - Busy=1 in cycles 1-3.
  - Mem_ready=1 only in cycle 3.
  - Mem_error=0.
- Read-back: MemRead=1, Address=0x10 after the previous test → Read_data=0xDEADBEEF with Mem_ready in cycle 3, held after.
- Misaligned: MemWrite=1, Address=0x12, Write_data=0x1 → Mem_ready and Mem_error pulse together in cycle 3. A later read of 0x10 still returns 0xDEADBEEF.
- Wrap and conflict, DEPTH_LOG2=8:
  - Write 0x55 to Address 0x400 → a read of 0x0 returns 0x55.
  - MemRead=MemWrite=1 at 0x20 with 0x77 → Mem_error=1, and a later read of 0x20 returns 0x77.
- Held request with LATENCY=1: MemRead held high for 6 cycles → Mem_ready in cycles 1, 3, 5 only; Busy alternates.
- Reset mid-write: MemWrite to 0x30 with 0xAAAA; RESET low in cycle 2, released in cycle 3.
  - Mem_ready never pulses.
  - A later read of 0x30 returns the old value, 0x0 after the bench pre-writes 0.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder for the core's load/store
//                path. A request (MemRead/MemWrite level) is sampled in IDLE,
//                served from an internal word array LATENCY cycles later, and
//                completion is signalled with a one-cycle Mem_ready pulse.
//
//  Parameters  : DEPTH_LOG2 - array holds 2**DEPTH_LOG2 32-bit words
//                LATENCY    - cycles from request sample to Mem_ready (1..15)
//
//  Ports       : CLK        in   clock, rising edge
//                RESET      in   asynchronous active-low reset
//                MemRead    in   read request level
//                MemWrite   in   write request level
//                Address    in   byte address, word index = [DEPTH_LOG2+1:2]
//                Write_data in   store data
//                Read_data  out  load data, valid with Mem_ready, then held
//                Mem_ready  out  one-cycle completion pulse
//                Mem_error  out  pulses with Mem_ready on a faulted access
//                Busy       out  high whenever the responder is not idle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   output logic        Mem_ready,
   output logic        Mem_error,
   output logic        Busy
);

   localparam int         C_WORDS    = 1 << DEPTH_LOG2;
   localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;

   // Captured request
   logic [DEPTH_LOG2-1:0] idx_q;
   logic                  misal_q;
   logic                  write_q;
   logic                  conflict_q;
   logic [31:0]           wdata_q;

   // Registered outputs
   logic [31:0]           rdata_q;
   logic                  ready_q;
   logic                  error_q;
   logic                  busy_q;

   // Word array: not reset, contents undefined at power-up
   logic [31:0]           mem_q [C_WORDS];

   logic                  w_req;
   logic                  w_capture;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_misal;
   logic                  w_write;
   logic                  w_conflict;
   logic [31:0]           w_wdata;
   logic                  w_commit;
   logic [31:0]           w_unused_addr;

   assign w_req     = MemRead | MemWrite;
   assign w_capture = (state_q == S_IDLE) && w_req;

   // With LATENCY=1 the commit edge is the capture edge, so the access is
   // taken straight from the inputs; otherwise from the captured copy.
   always_comb begin
      if (state_q == S_IDLE) begin
         w_idx      = Address[DEPTH_LOG2+1:2];
         w_misal    = (Address[1:0] != 2'b00);
         w_write    = MemWrite;
         w_conflict = MemRead & MemWrite;
         w_wdata    = Write_data;
      end else begin
         w_idx      = idx_q;
         w_misal    = misal_q;
         w_write    = write_q;
         w_conflict = conflict_q;
         w_wdata    = wdata_q;
      end
   end

   // Upper address bits simply wrap
   assign w_unused_addr = Address;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               cnt_d = C_CNT_INIT;
               if (LATENCY == 1) state_d = S_DONE;
               else              state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) state_d = S_DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Access commits on the edge entering DONE; RESET gating keeps a held
   // request from writing the array while reset is asserted.
   assign w_commit = RESET && (state_d == S_DONE);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= '0;
         misal_q    <= 1'b0;
         write_q    <= 1'b0;
         conflict_q <= 1'b0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         ready_q    <= 1'b0;
         error_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (w_capture) begin
            idx_q      <= Address[DEPTH_LOG2+1:2];
            misal_q    <= (Address[1:0] != 2'b00);
            write_q    <= MemWrite;
            conflict_q <= MemRead & MemWrite;
            wdata_q    <= Write_data;
         end
         ready_q <= (state_d == S_DONE);
         error_q <= (state_d == S_DONE) && (w_misal || w_conflict);
         busy_q  <= (state_d != S_IDLE);
         if (w_commit && !w_write) begin
            rdata_q <= w_misal ? 32'd0 : mem_q[w_idx];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_commit && w_write && !w_misal) begin
         mem_q[w_idx] <= w_wdata;
      end
   end

   assign Read_data = rdata_q;
   assign Mem_ready = ready_q;
   assign Mem_error = error_q;
   assign Busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder. Two
//                instances share clock and reset: one with LATENCY=3 for the
//                main access sequences, one with LATENCY=1 for back-to-back
//                service of a held request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        rd3, wr3, rd1, wr1;
   logic [31:0] addr3, wd3, addr1, wd1;
   logic [31:0] rdata3, rdata1;
   logic        rdy3, err3, busy3, rdy1, err1, busy1;

   int          n_cmp = 0;
   int          n_err = 0;

   // Per-access observation (bit c = value seen in cycle c)
   logic [6:0]  rdy_mask, busy_mask;
   logic        err_seen;
   logic [31:0] rd_val, held_val;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_LOG2(8), .LATENCY(3)) u_dut3 (
      .CLK(clk), .RESET(rst_n), .MemRead(rd3), .MemWrite(wr3),
      .Address(addr3), .Write_data(wd3), .Read_data(rdata3),
      .Mem_ready(rdy3), .Mem_error(err3), .Busy(busy3)
   );

   dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
      .CLK(clk), .RESET(rst_n), .MemRead(rd1), .MemWrite(wr1),
      .Address(addr1), .Write_data(wd1), .Read_data(rdata1),
      .Mem_ready(rdy1), .Mem_error(err1), .Busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One access on the LATENCY=3 instance: request raised in cycle 0, held
   // until Mem_ready is seen, observed for cycles 1..6 (bounded).
   task automatic do3(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      rd3 = rd; wr3 = wr; addr3 = a; wd3 = d;
      rdy_mask = '0; busy_mask = '0; err_seen = 1'b0; rd_val = 32'hx;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         rdy_mask[c]  = rdy3;
         busy_mask[c] = busy3;
         if (rdy3) begin
            err_seen = err3;
            rd_val   = rdata3;
            rd3 = 1'b0; wr3 = 1'b0;
         end
      end
      held_val = rdata3;
      rd3 = 1'b0; wr3 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      rd3 = 0; wr3 = 0; addr3 = 0; wd3 = 0;
      rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, rdy3}, 32'd0);
      chk("rst_error", {31'd0, err3}, 32'd0);
      chk("rst_busy",  {31'd0, busy3}, 32'd0);
      chk("rst_rdata", rdata3, 32'd0);
      rst_n = 1'b1;

      // Single write
      do3(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      chk("wr_ready_mask", {25'd0, rdy_mask},  32'b0001000);
      chk("wr_busy_mask",  {25'd0, busy_mask}, 32'b0001110);
      chk("wr_error",      {31'd0, err_seen},  32'd0);

      // Read-back
      do3(1'b1, 1'b0, 32'h10, 32'h0);
      chk("rb_ready_mask", {25'd0, rdy_mask}, 32'b0001000);
      chk("rb_data",       rd_val,   32'hDEADBEEF);
      chk("rb_held",       held_val, 32'hDEADBEEF);
      chk("rb_error",      {31'd0, err_seen}, 32'd0);

      // Misaligned write is dropped and flagged
      do3(1'b0, 1'b1, 32'h12, 32'h1);
      chk("mis_ready_mask", {25'd0, rdy_mask}, 32'b0001000);
      chk("mis_error",      {31'd0, err_seen}, 32'd1);
      do3(1'b1, 1'b0, 32'h10, 32'h0);
      chk("mis_after_data", rd_val, 32'hDEADBEEF);

      // Misaligned read returns zero and flags
      do3(1'b1, 1'b0, 32'h13, 32'h0);
      chk("misrd_data",  rd_val, 32'd0);
      chk("misrd_error", {31'd0, err_seen}, 32'd1);

      // Address wrap
      do3(1'b0, 1'b1, 32'h400, 32'h55);
      chk("wrap_wr_error", {31'd0, err_seen}, 32'd0);
      do3(1'b1, 1'b0, 32'h0, 32'h0);
      chk("wrap_data", rd_val, 32'h55);

      // Read/write conflict: flagged, write still performed
      do3(1'b1, 1'b1, 32'h20, 32'h77);
      chk("conf_error", {31'd0, err_seen}, 32'd1);
      do3(1'b1, 1'b0, 32'h20, 32'h0);
      chk("conf_data",  rd_val, 32'h77);
      chk("conf_rd_error", {31'd0, err_seen}, 32'd0);

      // LATENCY=1: pre-write, then hold a read for six cycles
      @(posedge clk); #1;
      wr1 = 1'b1; addr1 = 32'h8; wd1 = 32'h1234;
      @(posedge clk); #1;
      chk("l1_wr_ready", {31'd0, rdy1}, 32'd1);
      wr1 = 1'b0;
      @(posedge clk); #1;
      rd1 = 1'b1; addr1 = 32'h8;
      rdy_mask = '0; busy_mask = '0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         rdy_mask[c]  = rdy1;
         busy_mask[c] = busy1;
      end
      rd1 = 1'b0;
      chk("l1_ready_mask", {25'd0, rdy_mask},  32'b0101010);
      chk("l1_busy_mask",  {25'd0, busy_mask}, 32'b0101010);
      chk("l1_data",       rdata1, 32'h1234);

      // Reset mid-write discards the uncommitted write
      do3(1'b0, 1'b1, 32'h30, 32'h0);
      chk("pre_wr_ready", {25'd0, rdy_mask}, 32'b0001000);
      @(posedge clk); #1;                        // cycle 0
      wr3 = 1'b1; addr3 = 32'h30; wd3 = 32'hAAAA;
      rdy_mask = '0;
      @(posedge clk); #1;                        // cycle 1
      chk("mid_busy_c1", {31'd0, busy3}, 32'd1);
      rdy_mask[1] = rdy3;
      @(posedge clk); #1;                        // cycle 2
      rdy_mask[2] = rdy3;
      rst_n = 1'b0; wr3 = 1'b0;
      #1;
      chk("mid_rst_busy",  {31'd0, busy3}, 32'd0);
      chk("mid_rst_rdata", rdata3, 32'd0);
      @(posedge clk); #1;                        // cycle 3
      rdy_mask[3] = rdy3;
      rst_n = 1'b1;
      for (int c = 4; c <= 6; c++) begin
         @(posedge clk); #1;
         rdy_mask[c] = rdy3;
      end
      chk("mid_no_ready", {25'd0, rdy_mask}, 32'd0);
      do3(1'b1, 1'b0, 32'h30, 32'h0);
      chk("mid_old_data", rd_val, 32'd0);
      chk("mid_rd_ready", {25'd0, rdy_mask}, 32'b0001000);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
